// File: rtl/jpeg_stream_feeder.sv
// jpeg_stream_feeder
//   Feeds entropy-coded JPEG scan bytes to the entropy decoder input bus.
//   It removes 0xFF00 byte stuffing and drops 0xFF fill bytes. It stops at the
//   first marker: EOI ends the scan cleanly, and any other marker sets marker_err.
//   Bytes are packed MSB-first into OUT_W-bit words. A partial last word is
//   padded with 0xFF. Each word is handed over while the decoder asserts request.
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   start               : pulse, begins a new scan from IDLE/DONE
//   byte_in/byte_valid  : scan byte stream in; byte_ready = accept
//   data_out/valid_out  : packed word out, transfers when request is high
//   request             : decoder pull request
//   done                : scan finished and final word delivered
//   marker_err          : sticky, scan ended on a non-EOI marker
//   word_count          : words transferred this scan, saturating
module jpeg_stream_feeder #(
  parameter int unsigned OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic [OUT_W-1:0] data_out,
  output logic             valid_out,
  input  logic             request,
  output logic             done,
  output logic             marker_err,
  output logic [15:0]      word_count
);

  localparam int unsigned NB = OUT_W / 8;
  localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_FF_SEEN, S_FLUSH, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    acc_cnt_q, acc_cnt_d;
  logic [OUT_W-1:0] hold_q, hold_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             marker_err_q, marker_err_d;
  logic [15:0]      word_count_q, word_count_d;

  logic             word_full, xfer, hold_free, ready_c, accept;
  logic             push, load;
  logic [7:0]       push_byte;
  logic [OUT_W-1:0] load_word, pad_word;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    acc_cnt_d    = acc_cnt_q;
    hold_d       = hold_q;
    valid_d      = valid_q;
    done_d       = done_q;
    marker_err_d = marker_err_q;
    word_count_d = word_count_q;
    push         = 1'b0;
    push_byte    = '0;
    load         = 1'b0;
    load_word    = '0;

    word_full = (acc_cnt_q == CW'(NB - 1));
    xfer      = valid_q && request;
    hold_free = !valid_q || request;
    // Stall only the byte that would complete a word while the holding
    // register cannot drain. A byte that would not push anything is stalled
    // too, because the stall condition ignores the byte value.
    ready_c   = (state_q == S_SCAN || state_q == S_FF_SEEN) &&
                !(word_full && valid_q && !request);
    accept    = byte_valid && ready_c;

    // Shift 0xFF in from the right until the held bytes reach the MSB end.
    pad_word = acc_q;
    for (int unsigned i = 0; i < NB; i++) begin
      if (i < NB - 32'(acc_cnt_q)) pad_word = {pad_word[OUT_W-9:0], 8'hFF};
    end

    if (xfer) begin
      valid_d = 1'b0;
      if (word_count_q != '1) word_count_d = word_count_q + 16'd1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_SCAN;
          acc_d        = '0;
          acc_cnt_d    = '0;
          word_count_d = '0;
          marker_err_d = 1'b0;
          done_d       = 1'b0;
        end
      end
      S_SCAN: begin
        if (accept) begin
          if (byte_in == 8'hFF) begin
            state_d = S_FF_SEEN;
          end else begin
            push      = 1'b1;
            push_byte = byte_in;
          end
        end
      end
      S_FF_SEEN: begin
        if (accept) begin
          case (byte_in)
            8'h00: begin
              push      = 1'b1;
              push_byte = 8'hFF;
              state_d   = S_SCAN;
            end
            8'hFF: ;
            8'hD9: state_d = S_FLUSH;
            default: begin
              marker_err_d = 1'b1;
              state_d      = S_FLUSH;
            end
          endcase
        end
      end
      S_FLUSH: begin
        if (acc_cnt_q != '0) begin
          if (hold_free) begin
            load      = 1'b1;
            load_word = pad_word;
            acc_cnt_d = '0;
          end
        end else if (!valid_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      acc_d = {acc_q[OUT_W-9:0], push_byte};
      if (word_full) begin
        load      = 1'b1;
        load_word = acc_d;
        acc_cnt_d = '0;
      end else begin
        acc_cnt_d = acc_cnt_q + CW'(1);
      end
    end

    if (load) begin
      hold_d  = load_word;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      acc_cnt_q    <= '0;
      hold_q       <= '0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      marker_err_q <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      acc_cnt_q    <= acc_cnt_d;
      hold_q       <= hold_d;
      valid_q      <= valid_d;
      done_q       <= done_d;
      marker_err_q <= marker_err_d;
      word_count_q <= word_count_d;
    end
  end

  assign byte_ready = ready_c;
  assign data_out   = hold_q;
  assign valid_out  = valid_q;
  assign done       = done_q;
  assign marker_err = marker_err_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_jpeg_stream_feeder.sv
// tb_jpeg_stream_feeder
//   Directed test of jpeg_stream_feeder with OUT_W=32. Inputs change on the
//   falling edge. Outputs are sampled on the falling edge, or 1 time unit
//   before the rising edge.
module tb_jpeg_stream_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] data_out;
  logic        valid_out;
  logic        request;
  logic        done;
  logic        marker_err;
  logic [15:0] word_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] got_q[$];

  jpeg_stream_feeder #(.OUT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .request    (request),
    .done       (done),
    .marker_err (marker_err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  // Word collector: records each transfer just before the rising edge where it happens.
  always begin
    @(negedge clk);
    #4;
    if (valid_out && request) got_q.push_back(data_out);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    logic acc;
    int unsigned n;
    byte_in    = b;
    byte_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      #4;
      acc = byte_ready;
      @(negedge clk);
      n++;
    end
    byte_valid = 1'b0;
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int unsigned n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; byte_in = '0; byte_valid = 1'b0; request = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_marker_err", {31'd0, marker_err}, 32'd0);
    chk("rst_word_count", {16'd0, word_count}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: basic packing, partial final word padded
    got_q.delete();
    pulse_start();
    send(8'h12); send(8'h34); send(8'h56); send(8'h78); send(8'h9A); send(8'hFF); send(8'hD9);
    wait_done("t1_done");
    chk("t1_nwords", got_q.size(), 32'd2);
    chk("t1_w0", got_q.size() > 0 ? got_q[0] : 32'hx, 32'h12345678);
    chk("t1_w1", got_q.size() > 1 ? got_q[1] : 32'hx, 32'h9AFFFFFF);
    chk("t1_wc", {16'd0, word_count}, 32'd2);
    chk("t1_merr", {31'd0, marker_err}, 32'd0);

    // 2: stuffing removal and fill byte drop
    got_q.delete();
    pulse_start();
    chk("t2_done_drop", {31'd0, done}, 32'd0);
    send(8'hAB); send(8'hFF); send(8'h00); send(8'hCD); send(8'hFF); send(8'hFF);
    send(8'h00); send(8'hEF); send(8'hFF); send(8'hD9);
    wait_done("t2_done");
    chk("t2_nwords", got_q.size(), 32'd2);
    chk("t2_w0", got_q.size() > 0 ? got_q[0] : 32'hx, 32'hABFFCDFF);
    chk("t2_w1", got_q.size() > 1 ? got_q[1] : 32'hx, 32'hEFFFFFFF);

    // 3: backpressure while streaming 12 bytes
    got_q.delete();
    pulse_start();
    request = 1'b0;
    fork
      begin
        for (int i = 1; i <= 12; i++) send(8'(i));
      end
      begin
        repeat (9) @(negedge clk);
        #4;
        chk("t3_stall_ready", {31'd0, byte_ready}, 32'd0);
        chk("t3_stall_valid", {31'd0, valid_out}, 32'd1);
        chk("t3_stall_data", data_out, 32'h01020304);
        chk("t3_stall_wc", {16'd0, word_count}, 32'd0);
        @(negedge clk);
        request = 1'b1;
      end
    join
    send(8'hFF); send(8'hD9);
    wait_done("t3_done");
    chk("t3_nwords", got_q.size(), 32'd3);
    chk("t3_w0", got_q.size() > 0 ? got_q[0] : 32'hx, 32'h01020304);
    chk("t3_w1", got_q.size() > 1 ? got_q[1] : 32'hx, 32'h05060708);
    chk("t3_w2", got_q.size() > 2 ? got_q[2] : 32'hx, 32'h090A0B0C);
    chk("t3_wc", {16'd0, word_count}, 32'd3);

    // 4: non-EOI marker
    got_q.delete();
    pulse_start();
    send(8'h11); send(8'h22); send(8'hFF); send(8'hD3);
    wait_done("t4_done");
    chk("t4_merr", {31'd0, marker_err}, 32'd1);
    chk("t4_nwords", got_q.size(), 32'd1);
    chk("t4_w0", got_q.size() > 0 ? got_q[0] : 32'hx, 32'h1122FFFF);
    pulse_start();
    chk("t4_merr_clr", {31'd0, marker_err}, 32'd0);
    chk("t4_done_clr", {31'd0, done}, 32'd0);
    send(8'hFF); send(8'hD9);
    wait_done("t4_done2");

    // 5: reset mid-word discards pending bytes
    got_q.delete();
    pulse_start();
    send(8'hAA); send(8'hBB);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_start();
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'hFF); send(8'hD9);
    wait_done("t5_done");
    chk("t5_nwords", got_q.size(), 32'd1);
    chk("t5_w0", got_q.size() > 0 ? got_q[0] : 32'hx, 32'h11223344);
    chk("t5_wc", {16'd0, word_count}, 32'd1);

    // 6: exact word boundary, no pad word
    got_q.delete();
    pulse_start();
    for (int i = 0; i < 8; i++) send(8'h80 + 8'(i));
    send(8'hFF); send(8'hD9);
    wait_done("t6_done");
    chk("t6_nwords", got_q.size(), 32'd2);
    chk("t6_w0", got_q.size() > 0 ? got_q[0] : 32'hx, 32'h80818283);
    chk("t6_w1", got_q.size() > 1 ? got_q[1] : 32'hx, 32'h84858687);
    chk("t6_wc", {16'd0, word_count}, 32'd2);

    // 6b: word_count saturation
    got_q.delete();
    pulse_start();
    force dut.word_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.word_count_q;
    @(negedge clk);
    chk("t6_wc_forced", {16'd0, word_count}, 32'h0000FFFF);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'hFF); send(8'hD9);
    wait_done("t6_sat_done");
    chk("t6_sat_nwords", got_q.size(), 32'd1);
    chk("t6_wc_sat", {16'd0, word_count}, 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
